// File: rtl/axi4_lite_slv_reg_file_if.sv
// AXI4-Lite bundle shared by the register-file slave and whatever master
// drives it. Protection bits are not carried because the slave ignores them.
interface axi4_lite_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    // Write address channel
    logic                  awvalid;
    logic                  awready;
    logic [ADDR_W-1:0]     awaddr;
    // Write data channel
    logic                  wvalid;
    logic                  wready;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W/8-1:0]   wstrb;
    // Write response channel
    logic                  bvalid;
    logic                  bready;
    logic [1:0]            bresp;
    // Read address channel
    logic                  arvalid;
    logic                  arready;
    logic [ADDR_W-1:0]     araddr;
    // Read data channel
    logic                  rvalid;
    logic                  rready;
    logic [DATA_W-1:0]     rdata;
    logic [1:0]            rresp;

    modport slv_port (
        input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport mst_port (
        output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/axi4_lite_slv_reg_file.sv
// axi4_lite_slv_reg_file
//   AXI4-Lite slave holding NUM_REGS word registers. Registers flagged in
//   RO_REG_MASK read back fabric values from i_ro_vals and reject writes with
//   SLVERR; word addresses beyond the file answer DECERR. AW and W are
//   accepted independently and in any order; one write and one read may be
//   outstanding at a time, and the two directions never interact.
//   Optional feature macro: AXI4_LITE_SLV_REG_FILE_WR_PULSE_EN adds the
//   o_wr_pulse port, a one-cycle strobe per register on every OKAY write.
module axi4_lite_slv_reg_file #(
    parameter int unsigned          AXI4_LITE_ADDR_BIT_WIDTH = 32,
    parameter int unsigned          AXI4_LITE_DATA_BIT_WIDTH = 32,
    parameter int unsigned          NUM_REGS                 = 8,
    parameter logic [NUM_REGS-1:0]  RO_REG_MASK              = '0
) (
    input  logic                                         i_clk,
    input  logic                                         i_sync_rst,
    axi4_lite_if.slv_port                                if_s_axi4_lite,
    input  logic [NUM_REGS*AXI4_LITE_DATA_BIT_WIDTH-1:0] i_ro_vals,
    output logic [NUM_REGS*AXI4_LITE_DATA_BIT_WIDTH-1:0] o_regs
`ifdef AXI4_LITE_SLV_REG_FILE_WR_PULSE_EN
    ,
    output logic [NUM_REGS-1:0]                          o_wr_pulse
`endif
);

    localparam int unsigned DATA_W   = AXI4_LITE_DATA_BIT_WIDTH;
    localparam int unsigned ADDR_W   = AXI4_LITE_ADDR_BIT_WIDTH;
    localparam int unsigned STRB_W   = DATA_W / 8;
    localparam int unsigned ADDR_LSB = $clog2(STRB_W);
    localparam int unsigned WORD_W   = ADDR_W - ADDR_LSB;
    localparam int unsigned IDX_W    = $clog2(NUM_REGS);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // True when a word address lands inside the register file.
    function automatic logic word_in_range(input logic [WORD_W-1:0] word);
        return (word < WORD_W'(NUM_REGS));
    endfunction

    // Byte-lane merge: lanes with a set strobe take the new data.
    function automatic logic [DATA_W-1:0] merge_bytes(
        input logic [DATA_W-1:0] old_data,
        input logic [DATA_W-1:0] wr_data,
        input logic [STRB_W-1:0] strb
    );
        logic [DATA_W-1:0] res;
        res = old_data;
        for (int b = 0; b < int'(STRB_W); b++) begin
            if (strb[b]) begin
                res[8*b +: 8] = wr_data[8*b +: 8];
            end else begin
                res[8*b +: 8] = old_data[8*b +: 8];
            end
        end
        return res;
    endfunction

    // Write-side state
    logic                  awready_q, awready_d;
    logic [WORD_W-1:0]     awaddr_q,  awaddr_d;
    logic                  wready_q,  wready_d;
    logic [DATA_W-1:0]     wdata_q,   wdata_d;
    logic [STRB_W-1:0]     wstrb_q,   wstrb_d;
    logic                  bvalid_q,  bvalid_d;
    logic [1:0]            bresp_q,   bresp_d;
    logic [DATA_W-1:0]     regs_q [NUM_REGS];
    logic [DATA_W-1:0]     regs_d [NUM_REGS];

    // Read-side state
    logic                  arready_q, arready_d;
    logic                  rvalid_q,  rvalid_d;
    logic [DATA_W-1:0]     rdata_q,   rdata_d;
    logic [1:0]            rresp_q,   rresp_d;

    // Handshakes and decode
    logic                  aw_hs_s;
    logic                  w_hs_s;
    logic                  b_hs_s;
    logic                  ar_hs_s;
    logic                  r_hs_s;
    logic                  commit_s;
    logic                  wr_in_range_s;
    logic [IDX_W-1:0]      wr_idx_s;
    logic                  wr_ok_s;
    logic [WORD_W-1:0]     rd_word_s;
    logic                  rd_in_range_s;
    logic [IDX_W-1:0]      rd_idx_s;
    logic [DATA_W-1:0]     ro_vals_s [NUM_REGS];
    logic                  unused_addr_lsb_s;

    assign aw_hs_s  = if_s_axi4_lite.awvalid && awready_q;
    assign w_hs_s   = if_s_axi4_lite.wvalid  && wready_q;
    assign b_hs_s   = bvalid_q && if_s_axi4_lite.bready;
    assign ar_hs_s  = if_s_axi4_lite.arvalid && arready_q;
    assign r_hs_s   = rvalid_q && if_s_axi4_lite.rready;

    // Both halves of the write are parked and no response is pending yet.
    assign commit_s      = !awready_q && !wready_q && !bvalid_q;
    assign wr_in_range_s = word_in_range(awaddr_q);
    assign wr_idx_s      = awaddr_q[IDX_W-1:0];
    assign wr_ok_s       = commit_s && wr_in_range_s && !RO_REG_MASK[wr_idx_s];

    assign rd_word_s     = if_s_axi4_lite.araddr[ADDR_W-1:ADDR_LSB];
    assign rd_in_range_s = word_in_range(rd_word_s);
    assign rd_idx_s      = rd_word_s[IDX_W-1:0];

    // Byte-offset address bits carry no meaning for word registers.
    assign unused_addr_lsb_s = ^{if_s_axi4_lite.awaddr[ADDR_LSB-1:0],
                                 if_s_axi4_lite.araddr[ADDR_LSB-1:0]};

    genvar gk;
    generate
        for (gk = 0; gk < int'(NUM_REGS); gk++) begin : g_slots
            assign ro_vals_s[gk]                 = i_ro_vals[gk*DATA_W +: DATA_W];
            assign o_regs[gk*DATA_W +: DATA_W]   = regs_q[gk];
        end
    endgenerate

    // Write path: independent AW/W capture, commit decode and B response hold.
    always_comb begin
        awready_d = awready_q;
        awaddr_d  = awaddr_q;
        wready_d  = wready_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        for (int k = 0; k < int'(NUM_REGS); k++) begin
            regs_d[k] = regs_q[k];
        end

        if (aw_hs_s) begin
            awready_d = 1'b0;
            awaddr_d  = if_s_axi4_lite.awaddr[ADDR_W-1:ADDR_LSB];
        end else begin
            awaddr_d  = awaddr_q;
        end

        if (w_hs_s) begin
            wready_d = 1'b0;
            wdata_d  = if_s_axi4_lite.wdata;
            wstrb_d  = if_s_axi4_lite.wstrb;
        end else begin
            wdata_d  = wdata_q;
        end

        if (commit_s) begin
            bvalid_d = 1'b1;
            if (!wr_in_range_s) begin
                bresp_d = RESP_DECERR;
            end else if (RO_REG_MASK[wr_idx_s]) begin
                bresp_d = RESP_SLVERR;
            end else begin
                bresp_d = RESP_OKAY;
            end
        end else if (b_hs_s) begin
            // Response taken: reopen both write channels for the next write.
            bvalid_d  = 1'b0;
            awready_d = 1'b1;
            wready_d  = 1'b1;
        end else begin
            bvalid_d  = bvalid_q;
        end

        if (wr_ok_s) begin
            regs_d[wr_idx_s] = merge_bytes(regs_q[wr_idx_s], wdata_q, wstrb_q);
        end else begin
            regs_d[wr_idx_s] = regs_q[wr_idx_s];
        end
    end

    // Read path: data and response are captured on the AR handshake edge and
    // held until the master takes them, so fabric RO values cannot tear.
    always_comb begin
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;

        if (ar_hs_s) begin
            arready_d = 1'b0;
            rvalid_d  = 1'b1;
            if (!rd_in_range_s) begin
                rdata_d = '0;
                rresp_d = RESP_DECERR;
            end else if (RO_REG_MASK[rd_idx_s]) begin
                rdata_d = ro_vals_s[rd_idx_s];
                rresp_d = RESP_OKAY;
            end else begin
                rdata_d = regs_q[rd_idx_s];
                rresp_d = RESP_OKAY;
            end
        end else if (r_hs_s) begin
            rvalid_d  = 1'b0;
            arready_d = 1'b1;
        end else begin
            rvalid_d  = rvalid_q;
        end
    end

    // State registers; reset discards any transaction in flight.
    always_ff @(posedge i_clk) begin
        if (i_sync_rst) begin
            awready_q <= 1'b1;
            awaddr_q  <= '0;
            wready_q  <= 1'b1;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            arready_q <= 1'b1;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
            for (int k = 0; k < int'(NUM_REGS); k++) begin
                regs_q[k] <= '0;
            end
        end else begin
            awready_q <= awready_d;
            awaddr_q  <= awaddr_d;
            wready_q  <= wready_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            for (int k = 0; k < int'(NUM_REGS); k++) begin
                regs_q[k] <= regs_d[k];
            end
        end
    end

`ifdef AXI4_LITE_SLV_REG_FILE_WR_PULSE_EN
    logic [NUM_REGS-1:0] wr_pulse_q, wr_pulse_d;

    // One-hot strobe for the register accepting an OKAY write this edge.
    always_comb begin
        wr_pulse_d = '0;
        if (wr_ok_s) begin
            wr_pulse_d[wr_idx_s] = 1'b1;
        end else begin
            wr_pulse_d = '0;
        end
    end

    // Pulse register, aligned with the o_regs update.
    always_ff @(posedge i_clk) begin
        if (i_sync_rst) begin
            wr_pulse_q <= '0;
        end else begin
            wr_pulse_q <= wr_pulse_d;
        end
    end

    assign o_wr_pulse = wr_pulse_q;
`endif

    assign if_s_axi4_lite.awready = awready_q;
    assign if_s_axi4_lite.wready  = wready_q;
    assign if_s_axi4_lite.bvalid  = bvalid_q;
    assign if_s_axi4_lite.bresp   = bresp_q;
    assign if_s_axi4_lite.arready = arready_q;
    assign if_s_axi4_lite.rvalid  = rvalid_q;
    assign if_s_axi4_lite.rdata   = rdata_q;
    assign if_s_axi4_lite.rresp   = rresp_q;

endmodule

// File: tb/tb_axi4_lite_slv_reg_file.sv
// Directed + randomized bench for axi4_lite_slv_reg_file. Expected values come
// from a word-array model updated with the register-file rules (range check,
// RO mask, byte strobes).
`timescale 1ns/1ps
module tb_axi4_lite_slv_reg_file;

    localparam int NREGS = 8;
    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam logic [NREGS-1:0] RO_MASK = 8'b0000_1000;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    logic                  clk = 1'b0;
    logic                  sync_rst;
    logic [NREGS*DW-1:0]   ro_vals;
    logic [NREGS*DW-1:0]   regs;
`ifdef AXI4_LITE_SLV_REG_FILE_WR_PULSE_EN
    logic [NREGS-1:0]      wr_pulse;
`endif

    axi4_lite_if #(.ADDR_W(AW), .DATA_W(DW)) axi ();

    axi4_lite_slv_reg_file #(
        .AXI4_LITE_ADDR_BIT_WIDTH (AW),
        .AXI4_LITE_DATA_BIT_WIDTH (DW),
        .NUM_REGS                 (NREGS),
        .RO_REG_MASK              (RO_MASK)
    ) dut (
        .i_clk          (clk),
        .i_sync_rst     (sync_rst),
        .if_s_axi4_lite (axi),
        .i_ro_vals      (ro_vals),
        .o_regs         (regs)
`ifdef AXI4_LITE_SLV_REG_FILE_WR_PULSE_EN
        ,
        .o_wr_pulse     (wr_pulse)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] model [NREGS];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ro(input int k, input logic [DW-1:0] v);
        ro_vals[k*DW +: DW] = v;
    endtask

    task automatic check_regs(input string tag);
        for (int k = 0; k < NREGS; k++) begin
            chk($sformatf("%s_reg%0d", tag, k), regs[k*DW +: DW], RO_MASK[k] ? '0 : model[k]);
        end
    endtask

    // One full write transaction with chosen channel delays and B stall.
    task automatic axi_write(input string tag, input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int aw_dly, input int w_dly,
                             input int b_dly, input bit chk_lat);
        int word;
        logic [1:0] exp_resp;
        bit aw_done, w_done, aw_hs, w_hs;
        int n, lat;
`ifdef AXI4_LITE_SLV_REG_FILE_WR_PULSE_EN
        logic [NREGS-1:0] one, exp_pulse;
        one = 1;
`endif
        word = int'(addr >> 2);
        if (word >= NREGS)     exp_resp = DECERR;
        else if (RO_MASK[word]) exp_resp = SLVERR;
        else                    exp_resp = OKAY;

        aw_done = 0; w_done = 0; n = 0;
        while (!(aw_done && w_done) && n < 60) begin
            axi.awaddr  = addr;
            axi.awvalid = !aw_done && (n >= aw_dly);
            axi.wdata   = data;
            axi.wstrb   = strb;
            axi.wvalid  = !w_done && (n >= w_dly);
            aw_hs = axi.awvalid && axi.awready;
            w_hs  = axi.wvalid && axi.wready;
            tick();
            if (aw_hs) aw_done = 1;
            if (w_hs)  w_done = 1;
            n++;
        end
        axi.awvalid = 1'b0;
        axi.wvalid  = 1'b0;
        chk({tag, "_aw_w_accepted"}, aw_done && w_done, 1);

        lat = 0;
        while (!axi.bvalid && lat < 20) begin
            tick();
            lat++;
        end
        chk({tag, "_bvalid"}, axi.bvalid, 1);
        if (chk_lat) chk({tag, "_b_latency"}, lat, 1);
        chk({tag, "_bresp"}, axi.bresp, exp_resp);

        if (exp_resp == OKAY) begin
            for (int b = 0; b < 4; b++) begin
                if (strb[b]) model[word][8*b +: 8] = data[8*b +: 8];
            end
        end
`ifdef AXI4_LITE_SLV_REG_FILE_WR_PULSE_EN
        exp_pulse = (exp_resp == OKAY) ? (one << word) : '0;
        chk({tag, "_pulse"}, wr_pulse, exp_pulse);
`endif
        check_regs(tag);

        for (int i = 0; i < b_dly; i++) begin
            tick();
            chk({tag, "_bvalid_hold"}, axi.bvalid, 1);
            chk({tag, "_bresp_hold"}, axi.bresp, exp_resp);
            chk({tag, "_awready_low"}, axi.awready, 0);
            chk({tag, "_wready_low"}, axi.wready, 0);
`ifdef AXI4_LITE_SLV_REG_FILE_WR_PULSE_EN
            if (i == 0) chk({tag, "_pulse_one_cycle"}, wr_pulse, 0);
`endif
        end
        axi.bready = 1'b1;
        tick();
        axi.bready = 1'b0;
`ifdef AXI4_LITE_SLV_REG_FILE_WR_PULSE_EN
        if (b_dly == 0) chk({tag, "_pulse_one_cycle"}, wr_pulse, 0);
`endif
        chk({tag, "_bvalid_clear"}, axi.bvalid, 0);
        chk({tag, "_awready_back"}, axi.awready, 1);
        chk({tag, "_wready_back"}, axi.wready, 1);
    endtask

    // One read transaction with an R stall, optionally churning RO inputs.
    task automatic axi_read(input string tag, input logic [31:0] addr, input int r_dly, input bit vary_ro);
        int word, n;
        logic [DW-1:0] exp_data;
        logic [1:0] exp_resp;
        n = 0;
        while (!axi.arready && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_arready_idle"}, axi.arready, 1);
        word = int'(addr >> 2);
        if (word >= NREGS) begin
            exp_data = '0; exp_resp = DECERR;
        end else if (RO_MASK[word]) begin
            exp_data = ro_vals[word*DW +: DW]; exp_resp = OKAY;
        end else begin
            exp_data = model[word]; exp_resp = OKAY;
        end
        axi.araddr  = addr;
        axi.arvalid = 1'b1;
        tick();
        axi.arvalid = 1'b0;
        chk({tag, "_rvalid"}, axi.rvalid, 1);
        chk({tag, "_rdata"}, axi.rdata, exp_data);
        chk({tag, "_rresp"}, axi.rresp, exp_resp);
        for (int i = 0; i < r_dly; i++) begin
            if (vary_ro) begin
                for (int k = 0; k < NREGS; k++) set_ro(k, $urandom);
            end
            tick();
            chk({tag, "_rvalid_hold"}, axi.rvalid, 1);
            chk({tag, "_rdata_hold"}, axi.rdata, exp_data);
            chk({tag, "_rresp_hold"}, axi.rresp, exp_resp);
            chk({tag, "_arready_low"}, axi.arready, 0);
        end
        axi.rready = 1'b1;
        tick();
        axi.rready = 1'b0;
        chk({tag, "_rvalid_clear"}, axi.rvalid, 0);
        chk({tag, "_arready_back"}, axi.arready, 1);
    endtask

    initial begin
        logic [DW-1:0] old_val, new_val;
        sync_rst    = 1'b1;
        ro_vals     = '0;
        axi.awvalid = 1'b0; axi.awaddr = '0;
        axi.wvalid  = 1'b0; axi.wdata  = '0; axi.wstrb = '0;
        axi.bready  = 1'b0;
        axi.arvalid = 1'b0; axi.araddr = '0;
        axi.rready  = 1'b0;
        for (int k = 0; k < NREGS; k++) model[k] = '0;
        repeat (3) tick();
        sync_rst = 1'b0;

        // Reset state
        chk("rst_awready", axi.awready, 1);
        chk("rst_wready",  axi.wready, 1);
        chk("rst_arready", axi.arready, 1);
        chk("rst_bvalid",  axi.bvalid, 0);
        chk("rst_rvalid",  axi.rvalid, 0);
        chk("rst_bresp",   axi.bresp, OKAY);
        chk("rst_rresp",   axi.rresp, OKAY);
        chk("rst_rdata",   axi.rdata, 0);
        check_regs("rst");

        // T1: AW and W together, full strobe
        axi_write("t1_wr", 32'h04, 32'hDEADBEEF, 4'hF, 0, 0, 0, 1);
        axi_read("t1_rd", 32'h04, 0, 0);

        // T2: W first, AW three cycles later, half strobe, B stalled
        axi_write("t2_pre", 32'h08, 32'hFFFF_FFFF, 4'hF, 0, 0, 0, 1);
        axi_write("t2_wr", 32'h08, 32'h1234_5678, 4'h3, 3, 0, 5, 1);
        chk("t2_reg2", regs[2*DW +: DW], 32'hFFFF_5678);

        // T3: read-only register
        set_ro(3, 32'hA5A5_A5A5);
        axi_write("t3_wr", 32'h0C, 32'h1111_2222, 4'hF, 1, 0, 0, 1);
        axi_read("t3_rd", 32'h0C, 0, 0);

        // T4: first word past the file
        axi_read("t4_rd", 32'h20, 1, 0);
        axi_write("t4_wr", 32'h20, 32'h5555_AAAA, 4'hF, 0, 2, 0, 1);

        // Randomized traffic
        for (int it = 0; it < 24; it++) begin
            int w_word;
            w_word = $urandom_range(0, 9);
            for (int k = 0; k < NREGS; k++) set_ro(k, $urandom);
            axi_write($sformatf("rnd%0d_wr", it), 32'(w_word * 4 + $urandom_range(0, 3)), $urandom,
                      4'($urandom_range(0, 15)), $urandom_range(0, 3), $urandom_range(0, 3),
                      $urandom_range(0, 2), 1);
            axi_read($sformatf("rnd%0d_rd", it), 32'($urandom_range(0, 9) * 4 + $urandom_range(0, 3)),
                     $urandom_range(0, 2), 0);
        end

        // T5: RO read stalled while fabric values change
        set_ro(3, 32'hC0FF_EE00);
        axi_read("t5_rd", 32'h0C, 4, 1);

        // Read accepted on the same edge a write commits returns the old word
        old_val = model[5];
        new_val = ~old_val;
        axi.awaddr = 32'h14; axi.awvalid = 1'b1;
        axi.wdata  = new_val; axi.wstrb = 4'hF; axi.wvalid = 1'b1;
        tick();
        axi.awvalid = 1'b0; axi.wvalid = 1'b0;
        axi.araddr = 32'h14; axi.arvalid = 1'b1;
        tick();
        axi.arvalid = 1'b0;
        chk("same_edge_bvalid", axi.bvalid, 1);
        chk("same_edge_rvalid", axi.rvalid, 1);
        chk("same_edge_rdata_old", axi.rdata, old_val);
        chk("same_edge_reg5_new", regs[5*DW +: DW], new_val);
        model[5] = new_val;
        axi.rready = 1'b1; axi.bready = 1'b1;
        tick();
        axi.rready = 1'b0; axi.bready = 1'b0;
        chk("same_edge_b_done", axi.bvalid, 0);
        chk("same_edge_r_done", axi.rvalid, 0);

        // Reset while a B response is pending
        axi.awaddr = 32'h18; axi.awvalid = 1'b1;
        axi.wdata  = 32'h0BAD_F00D; axi.wstrb = 4'hF; axi.wvalid = 1'b1;
        tick();
        axi.awvalid = 1'b0; axi.wvalid = 1'b0;
        tick();
        chk("rstb_bvalid_pending", axi.bvalid, 1);
        chk("rstb_reg6_written", regs[6*DW +: DW], 32'h0BAD_F00D);
        sync_rst = 1'b1;
        tick();
        sync_rst = 1'b0;
        for (int k = 0; k < NREGS; k++) model[k] = '0;
        chk("rstb_bvalid", axi.bvalid, 0);
        chk("rstb_awready", axi.awready, 1);
        chk("rstb_wready", axi.wready, 1);
        check_regs("rstb");

        // Traffic resumes cleanly after reset
        axi_write("post_wr", 32'h1C, 32'h7777_8888, 4'hC, 2, 1, 1, 1);
        axi_read("post_rd", 32'h1C, 1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
